// File: rtl/arb_request_agent.sv
// arb_request_agent
//   Requester-side agent for a 3-way fixed-priority grant arbiter.
//   Each channel queues jobs in a pending counter, raises r[i] while it
//   wants or holds the bus, and runs one BURST_LEN-beat transfer per job
//   on the grants it receives. Protocol anomalies are latched in sticky
//   flags until reset.
//
// Ports
//   clk           clock
//   resetn        synchronous, active-low reset
//   job_valid[i]  push one job onto channel i
//   job_ready[i]  channel i pending counter is not full
//   r[i]          request to arbiter (decoded from registered state only)
//   g[i]          grant from arbiter (lags r by one cycle)
//   xfer[i]       a beat is performed on channel i this cycle
//   done[i]       this beat is the last of the burst
//   err_preempt   sticky: grant withdrawn mid-burst
//   err_timeout   sticky: request waited TIMEOUT cycles without grant
//   err_multi     sticky: more than one grant bit high in a cycle
//   err_spurious  sticky: grant seen on an idle channel outside the lag slot
module arb_request_agent #(
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned CNT_W     = 3,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:1] job_valid,
    output logic [3:1] job_ready,
    output logic [3:1] r,
    input  logic [3:1] g,
    output logic [3:1] xfer,
    output logic [3:1] done,
    output logic [3:1] err_preempt,
    output logic [3:1] err_timeout,
    output logic       err_multi,
    output logic [3:1] err_spurious
);

    localparam int unsigned     BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [7:0]      TIMEOUT_C = 8'(TIMEOUT);
    localparam logic [CNT_W-1:0] PEND_FULL = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER
    } state_t;

    logic err_multi_q;

    for (genvar i = 1; i <= 3; i++) begin : g_ch
        state_t            state_q;
        logic [CNT_W-1:0]  pend_q;
        logic [CNT_W-1:0]  pend_d;
        logic [BEAT_W-1:0] beat_q;
        logic [7:0]        wait_q;
        logic              just_done_q;
        logic              preempt_q;
        logic              timeout_q;
        logic              spurious_q;
        logic              active;
        logic              ready_c;
        logic              xfer_c;
        logic              done_c;
        logic              push;

        always_comb begin
            active  = (state_q != ST_IDLE);
            ready_c = (pend_q != PEND_FULL);
            xfer_c  = g[i] & active;
            done_c  = xfer_c & (beat_q == LAST_BEAT);
            push    = job_valid[i] & ready_c;
            pend_d  = pend_q;
            if (push && !done_c) begin
                pend_d = pend_q + CNT_W'(1);
            end else if (done_c && !push && (pend_q != '0)) begin
                pend_d = pend_q - CNT_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (!resetn) begin
                state_q     <= ST_IDLE;
                pend_q      <= '0;
                beat_q      <= '0;
                wait_q      <= '0;
                just_done_q <= 1'b0;
                preempt_q   <= 1'b0;
                timeout_q   <= 1'b0;
                spurious_q  <= 1'b0;
            end else begin
                pend_q      <= pend_d;
                just_done_q <= done_c;
                // A grant in the first idle cycle after done is the arbiter's
                // one-cycle lag; any later idle grant is unexpected.
                if (g[i] && (state_q == ST_IDLE) && !just_done_q) begin
                    spurious_q <= 1'b1;
                end
                case (state_q)
                    ST_IDLE: begin
                        if (pend_q != '0) begin
                            state_q <= ST_REQ;
                        end
                    end
                    ST_REQ: begin
                        if (g[i]) begin
                            wait_q <= '0;
                            if (BURST_LEN == 1) begin
                                state_q <= ST_IDLE;
                            end else begin
                                state_q <= ST_XFER;
                                beat_q  <= BEAT_W'(1);
                            end
                        end else begin
                            if (wait_q < TIMEOUT_C) begin
                                wait_q <= wait_q + 8'd1;
                            end
                            if (wait_q >= TIMEOUT_C - 8'd1) begin
                                timeout_q <= 1'b1;
                            end
                        end
                    end
                    ST_XFER: begin
                        if (g[i]) begin
                            if (beat_q == LAST_BEAT) begin
                                state_q <= ST_IDLE;
                                beat_q  <= '0;
                            end else begin
                                beat_q <= beat_q + BEAT_W'(1);
                            end
                        end else begin
                            preempt_q <= 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end

        assign job_ready[i]    = ready_c;
        assign r[i]            = active;
        assign xfer[i]         = xfer_c;
        assign done[i]         = done_c;
        assign err_preempt[i]  = preempt_q;
        assign err_timeout[i]  = timeout_q;
        assign err_spurious[i] = spurious_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_multi_q <= 1'b0;
        end else if ((g[1] & g[2]) | (g[1] & g[3]) | (g[2] & g[3])) begin
            err_multi_q <= 1'b1;
        end
    end

    assign err_multi = err_multi_q;

endmodule

// File: tb/tb_arb_request_agent.sv
module tb_arb_request_agent;

    localparam int BL   = 4;
    localparam int CW   = 3;
    localparam int TO   = 15;
    localparam int PMAX = (1 << CW) - 1;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [3:1] job_valid = '0;
    logic [3:1] g = '0;
    logic [3:1] job_ready, r, xfer, done, err_preempt, err_timeout, err_spurious;
    logic       err_multi;

    always #5 clk = ~clk;

    arb_request_agent #(.BURST_LEN(BL), .CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk(clk),
        .resetn(resetn),
        .job_valid(job_valid),
        .job_ready(job_ready),
        .r(r),
        .g(g),
        .xfer(xfer),
        .done(done),
        .err_preempt(err_preempt),
        .err_timeout(err_timeout),
        .err_multi(err_multi),
        .err_spurious(err_spurious)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: per channel, how many jobs are owed, whether a job is
    // being served, how many beats of it are done and how long it has waited.
    int         m_pend  [1:3];
    int         m_beats [1:3];
    int         m_waits [1:3];
    bit   [3:1] m_busy;
    bit   [3:1] m_after;
    bit   [3:1] m_pre, m_to, m_sp;
    bit         m_multi;
    logic [3:1] arb_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:1] arb_g();
        if (arb_prev[1]) return 3'b001;
        if (arb_prev[2]) return 3'b010;
        if (arb_prev[3]) return 3'b100;
        return 3'b000;
    endfunction

    task automatic model_reset();
        for (int i = 1; i <= 3; i++) begin
            m_pend[i]  = 0;
            m_beats[i] = 0;
            m_waits[i] = 0;
        end
        m_busy = '0; m_after = '0; m_pre = '0; m_to = '0; m_sp = '0;
        m_multi = 1'b0;
        arb_prev = '0;
    endtask

    task automatic cycle(input logic [3:1] jv, input logic [3:1] gv, input logic rn);
        logic [3:1] er, ex, ed, ejr;
        job_valid = jv;
        g         = gv;
        resetn    = rn;
        @(negedge clk);
        for (int i = 1; i <= 3; i++) begin
            er[i]  = m_busy[i];
            ex[i]  = gv[i] & m_busy[i];
            ed[i]  = ex[i] & (m_beats[i] == BL - 1);
            ejr[i] = (m_pend[i] < PMAX);
        end
        chk("r", 32'(r), 32'(er));
        chk("xfer", 32'(xfer), 32'(ex));
        chk("done", 32'(done), 32'(ed));
        chk("job_ready", 32'(job_ready), 32'(ejr));
        chk("err_preempt", 32'(err_preempt), 32'(m_pre));
        chk("err_timeout", 32'(err_timeout), 32'(m_to));
        chk("err_spurious", 32'(err_spurious), 32'(m_sp));
        chk("err_multi", 32'(err_multi), 32'(m_multi));
        @(posedge clk);
        if (!rn) begin
            model_reset();
        end else begin
            arb_prev = er;
            if ($countones(gv) > 1) m_multi = 1'b1;
            for (int i = 1; i <= 3; i++) begin
                bit push, start;
                push  = jv[i] && (m_pend[i] < PMAX);
                start = !m_busy[i] && (m_pend[i] > 0);
                if (gv[i] && !m_busy[i] && !m_after[i]) m_sp[i] = 1'b1;
                if (ex[i]) begin
                    m_waits[i] = 0;
                    if (ed[i]) begin
                        m_busy[i]  = 1'b0;
                        m_beats[i] = 0;
                        m_pend[i]--;
                    end else begin
                        m_beats[i]++;
                    end
                end else if (m_busy[i]) begin
                    if (m_beats[i] == 0) begin
                        if (m_waits[i] < TO) m_waits[i]++;
                        if (m_waits[i] >= TO) m_to[i] = 1'b1;
                    end else begin
                        m_pre[i] = 1'b1;
                    end
                end
                if (start) m_busy[i] = 1'b1;
                if (push) m_pend[i]++;
                m_after[i] = ed[i];
            end
        end
        #1;
    endtask

    task automatic arb_cycles(input logic [3:1] jv, input int n);
        for (int k = 0; k < n; k++) cycle(jv, arb_g(), 1'b1);
    endtask

    initial begin
        logic [3:1] jv, gv;
        logic       rn;
        int         rmode;
        model_reset();

        // Reset state
        cycle('0, '0, 1'b0);
        cycle('0, '0, 1'b0);
        chk("rst_r", 32'(r), 32'h0);
        chk("rst_job_ready", 32'(job_ready), 32'h7);
        chk("rst_flags", 32'({err_preempt, err_timeout, err_spurious, err_multi}), 32'h0);

        // Single ch1 job; grant stays high one cycle after done (lag, legal)
        cycle(3'b001, '0, 1'b1);
        arb_cycles('0, 9);
        chk("t1_r_idle", 32'(r), 32'h0);
        chk("t1_no_err", 32'({err_preempt, err_timeout, err_spurious, err_multi}), 32'h0);

        // Preemption: ch3 takes 2 beats, then ch1 steals the grant
        cycle(3'b100, arb_g(), 1'b1);
        cycle(3'b000, arb_g(), 1'b1);
        cycle(3'b001, arb_g(), 1'b1);
        arb_cycles('0, 16);
        chk("t2_preempt", 32'(err_preempt), 32'h4);
        chk("t2_r_idle", 32'(r), 32'h0);

        // Timeout: ch1 granted continuously, ch2 starves for 20 cycles
        cycle(3'b011, '0, 1'b1);
        cycle(3'b001, '0, 1'b1);
        cycle(3'b001, 3'b001, 1'b1);
        cycle(3'b001, 3'b001, 1'b1);
        for (int k = 0; k < 18; k++) cycle('0, 3'b001, 1'b1);
        chk("t3_timeout", 32'(err_timeout), 32'h2);
        chk("t3_r2_waiting", 32'(r[2]), 32'h1);
        arb_cycles('0, 10);
        chk("t3_r_idle", 32'(r), 32'h0);
        chk("t3_no_spurious", 32'(err_spurious), 32'h0);

        // Pending saturation: 8 pushes with no grants, 8th dropped
        for (int k = 0; k < 8; k++) cycle(3'b001, '0, 1'b1);
        chk("t4_full", 32'(job_ready[1]), 32'h0);
        arb_cycles(3'b001, 20);
        arb_cycles('0, 4);

        // Protocol errors
        cycle('0, '0, 1'b0);
        for (int k = 0; k < 3; k++) cycle('0, '0, 1'b1);
        cycle('0, 3'b011, 1'b1);
        cycle('0, 3'b010, 1'b1);
        cycle('0, 3'b010, 1'b1);
        for (int k = 0; k < 4; k++) cycle('0, '0, 1'b1);
        chk("t5_multi", 32'(err_multi), 32'h1);
        chk("t5_spurious", 32'(err_spurious), 32'h3);
        cycle('0, '0, 1'b0);
        chk("t5_cleared", 32'({err_preempt, err_timeout, err_spurious, err_multi}), 32'h0);

        // Reset mid-burst at beat 2 of ch1 with 3 jobs queued
        cycle(3'b001, arb_g(), 1'b1);
        cycle(3'b001, arb_g(), 1'b1);
        cycle(3'b001, arb_g(), 1'b1);
        arb_cycles('0, 2);
        cycle('0, arb_g(), 1'b0);
        chk("t6_r", 32'(r), 32'h0);
        chk("t6_job_ready", 32'(job_ready), 32'h7);
        chk("t6_flags", 32'({err_preempt, err_timeout, err_spurious, err_multi}), 32'h0);
        arb_cycles('0, 4);

        // Randomized traffic: alternating well-behaved arbiter and noisy grants
        rmode = 1;
        for (int n = 0; n < 800; n++) begin
            if (n % 60 == 0) rmode = $urandom_range(0, 1);
            jv = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            rn = ($urandom_range(0, 249) != 0);
            gv = (rmode != 0) ? arb_g() : 3'($urandom & $urandom);
            cycle(jv, gv, rn);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arb_request_agent.md
Name: arb_request_agent

Overview:
- Requester-side agent for the 3-way fixed-priority grant arbiter (r1 > r2 > r3).
- Queues per-channel jobs, drives r[3:1], and consumes g[3:1] to run one BURST_LEN-beat transfer per job.
- Flags protocol anomalies: preemption, grant timeout, multiple grants and spurious grants.
- Sits between job producers and the arbiter. The arbiter's grant lags r by one cycle: the arbiter registers r on clk and decodes g from its state.

Parameters:
- BURST_LEN, 4, granted beats per job (1..16).
- CNT_W, 3, width of each pending-job counter (max 2^CNT_W-1 jobs).
- TIMEOUT, 15, consecutive REQ cycles without grant before the timeout flag sets (1..255).

Ports:
- clk  input  1  clock
- resetn  input  1  reset, synchronous, active-low
- job_valid  input  [3:1]  per-channel job push
- job_ready  output  [3:1]  per-channel: pending counter not full
- r  output  [3:1]  request to arbiter
- g  input  [3:1]  grant from arbiter
- xfer  output  [3:1]  beat performed this cycle
- done  output  [3:1]  final beat of burst this cycle
- err_preempt  output  [3:1]  sticky: grant lost mid-burst
- err_timeout  output  [3:1]  sticky: REQ waited TIMEOUT cycles
- err_multi  output  1  sticky: more than one g bit high
- err_spurious  output  [3:1]  sticky: unexpected grant

Behaviour:
- Reset (resetn=0 at posedge): all states IDLE; pending, beat and wait counters 0; all sticky flags 0. Hence r=0, xfer=0, done=0, job_ready=3'b111.
- Mid-operation reset aborts bursts; pending jobs are lost.
- Channels i=1..3 are independent, identical instances. Priority comes from the arbiter only.
- Pending counter: push = job_valid[i] & job_ready[i]; pop = done[i].
  - Push and pop in the same cycle leave the count unchanged.
  - A push when full is ignored (job_ready=0).
  - The count never wraps.
- r[i] = 1 in REQ or XFER. It is decoded from registered state only, with no combinational path from g.
- xfer[i] = g[i] & (state is REQ or XFER).
- done[i] = xfer[i] & (beat==BURST_LEN-1).
- IDLE:
  - Go to REQ when the registered pending count is non-zero.
  - A push in the same cycle is not seen until the next cycle.
- REQ:
  - wait_cnt increments each cycle that g[i]=0. When it reaches TIMEOUT, set err_timeout[i] and keep waiting (no abort). wait_cnt saturates.
  - On g[i]=1: a beat happens that cycle and wait_cnt clears.
  - Next state after a beat: IDLE if it was the last beat (BURST_LEN=1), otherwise XFER.
- XFER:
  - g[i]=1: beat++, and go to IDLE on the last beat.
  - g[i]=0: hold the beat counter and state, keep r[i]=1, set err_preempt[i]. The burst resumes when the grant returns.
- After done, the channel spends at least one cycle in IDLE with r=0, then re-requests if jobs remain.
- Grant lag:
  - g[i]=1 in the first IDLE cycle after done is legal and ignored: no xfer, no error.
  - g[i]=1 while IDLE and the previous cycle was also IDLE sets err_spurious[i].
- err_multi sets in any cycle where more than one bit of g is high. Beats are still taken per channel.
- The beat counter is ceil(log2(BURST_LEN)) bits. It resets to 0 on done; it never wraps mid-burst.

Test Plan:
1. Single job, BURST_LEN=4: job_valid=3'b001 at cycle 0 → pending1=1 at c1, r=3'b001 at c2, g[1] at c3, xfer[1] at c3–c6, done[1] at c6, r=0 at c7. g[1] still high at c7 raises no error. job_ready stays 1 throughout.
2. Preemption: ch3 in XFER after 2 beats, then ch1 gets a job → g switches to 3'b001. Required: err_preempt[3]=1, ch3 r[3] held, beat count frozen at 2. Ch3 completes its remaining 2 beats once ch1 is done.
3. Timeout: ch2 requesting while ch1 is granted continuously for 20 cycles (TIMEOUT=15) → err_timeout[2] sets on the 15th wait cycle. Ch2 still requesting; it completes its burst once ch1 idles.
4. Pending saturation (CNT_W=3): push 8 jobs on ch1 with no grants → count=7, job_ready[1]=0, 8th push dropped. A push in the same cycle as done keeps the count constant.
5. Protocol errors:
   - g=3'b011 for one cycle → err_multi=1.
   - g[2]=1 for two cycles while ch2 has been IDLE 3 cycles → err_spurious[2]=1.
   - All flags persist until resetn=0.
6. Reset mid-burst: resetn=0 at beat 2 of ch1 with 3 jobs pending → next cycle r=0, pending=0, flags=0, job_ready=3'b111. No done is emitted.
